// File: rtl/pipelined_adder.sv
// Pipelined ripple adder/subtractor: one C-bit chunk per stage, carries registered between
// stages, valid/ready handshake with a global stall driven by the output slot.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned C = WIDTH / STAGES;

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic             w_stall;
  logic             w_v_src [STAGES];
  logic [WIDTH-1:0] w_a_src [STAGES];
  logic [WIDTH-1:0] w_b_src [STAGES];
  logic [WIDTH-1:0] w_s_src [STAGES];
  logic             w_c_src [STAGES];
  logic [C:0]       w_chunk [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic             w_c_nxt [STAGES];
  logic [WIDTH-1:0] w_res;
  logic             w_ovf_nxt;
  logic             w_zero_nxt;
  logic             w_neg_nxt;

  // A single stall freezes every stage so no slot is overwritten while the output waits.
  assign w_stall  = r_vld[STAGES-1] && !out_ready;
  assign in_ready = !w_stall && !reset;

  always_comb begin
    // Stage 0 sources come straight from the ports; B is inverted up front for subtract.
    w_v_src[0] = in_valid && in_ready;
    w_a_src[0] = A;
    w_b_src[0] = sub ? ~B : B;
    w_s_src[0] = '0;
    w_c_src[0] = sub ? 1'b1 : Cin;
    for (int k = 1; k < int'(STAGES); k++) begin
      w_v_src[k] = r_vld[k-1];
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_s_src[k] = r_s[k-1];
      w_c_src[k] = r_c[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      w_chunk[k] = {1'b0, w_a_src[k][k*C +: C]} + {1'b0, w_b_src[k][k*C +: C]}
                   + {{C{1'b0}}, w_c_src[k]};
      w_s_nxt[k] = w_s_src[k];
      w_s_nxt[k][k*C +: C] = w_chunk[k][C-1:0];
      w_c_nxt[k] = w_chunk[k][C];
    end
  end

  // Flags are derived from the completed sum as it enters the last register.
  assign w_res      = w_s_nxt[STAGES-1];
  assign w_ovf_nxt  = (w_a_src[STAGES-1][WIDTH-1] == w_b_src[STAGES-1][WIDTH-1])
                      && (w_res[WIDTH-1] != w_a_src[STAGES-1][WIDTH-1]);
  assign w_zero_nxt = (w_res == '0);
  assign w_neg_nxt  = w_res[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= w_v_src[k];
        r_a[k]   <= w_a_src[k];
        r_b[k]   <= w_b_src[k];
        r_s[k]   <= w_s_nxt[k];
        r_c[k]   <= w_c_nxt[k];
      end
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
      r_neg  <= w_neg_nxt;
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out       = r_s[STAGES-1];
  assign Cout      = r_c[STAGES-1];
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES (chunk width C = WIDTH/STAGES).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand set on A/B/Cin/sub is valid this cycle.
REQ-006 in_ready  out  1  block accepts an operand set this cycle.
REQ-007 A  in  WIDTH  operand A.
REQ-008 B  in  WIDTH  operand B.
REQ-009 Cin  in  1  carry-in, used only when sub=0.
REQ-010 sub  in  1  0 = add, 1 = subtract (A-B).
REQ-011 out_valid  out  1  result fields are valid this cycle.
REQ-012 out_ready  in  1  consumer accepts the result this cycle.
REQ-013 out  out  WIDTH  result.
REQ-014 Cout  out  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-015 overflow  out  1  two's-complement signed overflow.
REQ-016 zero  out  1  out == 0.
REQ-017 negative  out  1  out[WIDTH-1].

Function
REQ-018 Result SHALL equal A + (sub ? ~B : B) + (sub ? 1 : Cin), truncated to WIDTH bits, with the carry out of that sum on Cout.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k of the operands plus the registered carry from stage k-1 (stage 0 uses the effective carry-in); upper chunks are delayed and lower result chunks carried forward so each stage's adder spans only C bits.
REQ-020 overflow SHALL be 1 iff both effective operand MSBs are equal and the result MSB differs from them.
REQ-021 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure; throughput one operation per cycle.
REQ-023 Stall = out_valid && !out_ready; in_ready SHALL equal !stall && !reset.
REQ-024 During stall, every stage register, out, and all flags SHALL hold; no operation is dropped, duplicated, or reordered.
REQ-025 Bubbles (cycles without an input transfer) SHALL propagate as invalid slots; out_valid deasserts for those slots.
REQ-026 A stage SHALL advance when not stalled, even if downstream slots are empty (no bubble collapsing required).
REQ-027 Operations SHALL leave in strict input order.
REQ-028 Flags zero/negative/overflow/Cout SHALL be registered with out and valid in the same cycle as out_valid.
REQ-029 Output values while out_valid=0 are don't-care, except immediately after reset (REQ-030).

Reset
REQ-030 While reset=1 at a clock edge: all stage valid bits, out_valid, out, Cout, overflow, zero, negative SHALL become 0; in_ready SHALL be 0 while reset is high.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear on the output afterwards.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts (out_valid is 0).

Verification (WIDTH=32, STAGES=4 unless stated; out_ready=1 unless stated)
REQ-033 A=0x7FFFFFFF, B=1, sub=0, Cin=0 -> 4 cycles later out=0x80000000, overflow=1, negative=1, Cout=0, zero=0.
REQ-034 A=0xFFFFFFFF, B=1, sub=0 -> out=0x00000000, Cout=1, zero=1, overflow=0; ripple crosses all four chunks.
REQ-035 A=5, B=7, sub=1 -> out=0xFFFFFFFE, Cout=0, negative=1, overflow=0; A=7, B=5, sub=1 -> out=2, Cout=1.
REQ-036 Back-to-back ops (1+1, 2+2, 3+3) then out_ready=0 for 2 cycles when first result appears -> in_ready=0 those cycles, out=2 held, then 2, 4, 6 delivered in order with no loss.
REQ-037 Two ops in flight, reset asserted one cycle -> out_valid=0 next cycle and stays 0 for ≥4 cycles; neither result ever appears.
REQ-038 WIDTH=8, STAGES=1: A=0x12, B=0x00, Cin=1 -> out=0x13 after exactly 1 cycle; random 10^4-vector sweep against the REQ-018 model at WIDTH=32/STAGES=4 and WIDTH=16/STAGES=2.
